pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Generic, parametrised pipeline stage register for the MIPS core. It is the successor to the fixed per-stage registers and is intended to replace IF/ID, ID/EX, EX/MEM and MEM/WB. It carries a PC, an arbitrary data payload, a control bundle and the halt flag. Compared with the fixed registers it adds:
- a valid/ready handshake with an optional skid entry;
- flush-to-bubble;
- saturating stall and bubble counters for the debug unit.

## Interface
Parameters:
- NB_PC, 32, PC field width.
- NB_DATA, 128, payload width (concatenated operands, immediates, register indices).
- NB_CTRL, 16, control bundle width (EX/MEM/WB fields concatenated).
- SKID, 1, 1 = two-entry (main + skid), ready_o registered; 0 = single entry, ready_o combinational.
- NB_CNT, 16, width of each performance counter.

Ports (clock and reset first):
- clock_i  in  1  stage clock; all state updates on its falling edge.
- reset_i  in  1  synchronous, active-high reset.
- enable_pipe_i  in  1  global pipeline enable (debug step); 0 freezes all state.
- flush_i  in  1  discard stage contents, insert a bubble.
- valid_i  in  1  upstream entry valid.
- ready_o  out  1  stage can accept an entry.
- pc_i  in  NB_PC  upstream PC.
- data_i  in  NB_DATA  upstream payload.
- ctrl_i  in  NB_CTRL  upstream control.
- halt_detected_i  in  1  upstream halt flag.
- valid_o  out  1  downstream entry valid.
- ready_i  in  1  downstream can accept.
- pc_o  out  NB_PC  main-entry PC.
- data_o  out  NB_DATA  main-entry payload.
- ctrl_o  out  NB_CTRL  main-entry control; all zero when valid_o=0.
- halt_detected_o  out  1  main-entry halt flag, gated by valid_o.
- stall_count_o  out  NB_CNT  enabled cycles with valid_o=1 and ready_i=0.
- bubble_count_o  out  NB_CNT  enabled cycles with valid_o=0.

## Operation
- Transfers:
  - Input transfer = valid_i & ready_o & enable_pipe_i.
  - Output transfer = valid_o & ready_i & enable_pipe_i.
- State:
  - Main entry: main_valid, pc, data, ctrl, halt.
  - SKID=1 adds a skid entry with the same fields plus skid_valid.
- SKID=1 update rules, applied at each enabled falling edge:
  - ready_o = !skid_valid, from a register.
  - Output transfer with skid_valid=1: main takes the skid entry, and the skid takes the input if an input transfer occurs.
  - Output transfer with skid_valid=0: main takes the input if an input transfer occurs, otherwise main_valid←0.
  - No output transfer, main_valid=0: main takes the input if an input transfer occurs.
  - No output transfer, main_valid=1: the skid takes the input if an input transfer occurs.
- SKID=0 update rules:
  - ready_o = !main_valid | ready_i, combinational.
  - Main takes the input on an input transfer; otherwise main_valid clears on an output transfer.
- Ordering: entries leave in arrival order. No entry is duplicated or lost except by flush.
- Flush (flush_i=1 and enable_pipe_i=1) has priority over every other event:
  - main_valid←0 and skid_valid←0;
  - main ctrl←0 and main halt←0; data and pc hold;
  - an input transfer in the same cycle is discarded.
- Bubble outputs: ctrl_o and halt_detected_o are forced to 0 whenever valid_o=0, so downstream never sees stale control.
- enable_pipe_i=0: all registers hold, counters hold, no transfers. flush_i is ignored.
- Counters: increment on enabled cycles only, saturate at 2^NB_CNT−1 and never wrap. Both are evaluated before the same edge's state update.

## Timing
- Latency is one falling edge from input transfer to valid_o, when the stage is empty.
- Throughput is one entry per cycle while ready_i=1.
- Downstream stall:
  - SKID=1: one extra entry is absorbed. ready_o drops on the edge after the skid fills and rises on the edge after it drains.
  - SKID=0: ready_o follows ready_i in the same cycle.
- Reset (reset_i=1 at a falling edge) overrides enable and flush:
  - valid_o, ctrl_o, pc_o, data_o, halt_detected_o, both counters and skid_valid all go to 0;
  - ready_o=1;
  - input during the reset cycle is dropped;
  - reset mid-stall discards both entries.
- Simultaneous input and output transfers with skid_valid=0 keep occupancy constant (main replaced).

## Test plan
- Streaming:
  - Stimulus: reset, then SKID=1 with valid_i=1 and ready_i=1 for 4 cycles, pc_i = 0x0,0x4,0x8,0xC.
  - Required: pc_o shows 0x0..0xC on consecutive edges, one edge late; bubble_count_o=1 (first cycle); stall_count_o=0.
- Backpressure:
  - Stimulus: SKID=1, ready_i=0 while 3 entries (A,B,C) are offered.
  - Required: A held in main, B in skid, ready_o=0 after B, C not accepted; stall_count_o increments each stalled cycle.
  - Then ready_i=1: A,B,C emerge in order with no gaps.
- Flush:
  - Stimulus: flush_i=1 while main and skid are full and valid_i=1 (D).
  - Required: next edge valid_o=0, ctrl_o=0, halt_detected_o=0, ready_o=1; D never appears.
- Enable freeze:
  - Stimulus: enable_pipe_i=0 for 5 cycles with valid_i=1, ready_i toggling and flush_i=1.
  - Required: outputs and counters unchanged; after re-enable, the stream resumes from the held entry.
- Halt:
  - Stimulus: halt_detected_i=1 on entry pc=0x20.
  - Required: halt_detected_o=1 only while that entry is in main (valid_o=1).
- SKID=0 and saturation:
  - Stimulus: instantiate SKID=0 with NB_CNT=2 and hold ready_i=0 for 6 cycles.
  - Required: ready_o=0 combinationally while main is valid; stall_count_o saturates at 3.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: PC, payload, control and halt flag with a
// valid/ready handshake, optional skid entry, flush-to-bubble and debug counters.
module pipe_stage_reg #(
  parameter int NB_PC   = 32,
  parameter int NB_DATA = 128,
  parameter int NB_CTRL = 16,
  parameter int SKID    = 1,
  parameter int NB_CNT  = 16
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               enable_pipe_i,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [NB_PC-1:0]   pc_i,
  input  logic [NB_DATA-1:0] data_i,
  input  logic [NB_CTRL-1:0] ctrl_i,
  input  logic               halt_detected_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [NB_PC-1:0]   pc_o,
  output logic [NB_DATA-1:0] data_o,
  output logic [NB_CTRL-1:0] ctrl_o,
  output logic               halt_detected_o,
  output logic [NB_CNT-1:0]  stall_count_o,
  output logic [NB_CNT-1:0]  bubble_count_o
);

  typedef struct packed {
    logic [NB_PC-1:0]   pc;
    logic [NB_DATA-1:0] data;
    logic [NB_CTRL-1:0] ctrl;
    logic               halt;
  } entry_t;

  entry_t            in_entry;
  entry_t            main_q, main_d, skid_q, skid_d;
  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [NB_CNT-1:0] stall_q, stall_d, bubble_q, bubble_d;
  logic              in_xfer, out_xfer;

  assign in_entry = {pc_i, data_i, ctrl_i, halt_detected_i};

  // With a skid entry ready_o comes straight from a register; without it the
  // stage can accept whenever its single entry leaves in the same cycle.
  generate
    if (SKID != 0) begin : g_ready_skid
      assign ready_o = ~skid_valid_q;
    end else begin : g_ready_single
      assign ready_o = ~main_valid_q | ready_i;
    end
  endgenerate

  assign in_xfer  = valid_i & ready_o & enable_pipe_i;
  assign out_xfer = main_valid_q & ready_i & enable_pipe_i;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    stall_d      = stall_q;
    bubble_d     = bubble_q;

    // Counters look at the pre-edge state and stick at all-ones.
    if (enable_pipe_i) begin
      if (main_valid_q && !ready_i && stall_q != '1)
        stall_d = stall_q + NB_CNT'(1);
      if (!main_valid_q && bubble_q != '1)
        bubble_d = bubble_q + NB_CNT'(1);
    end

    if (enable_pipe_i) begin
      if (flush_i) begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
        main_d.ctrl  = '0;
        main_d.halt  = 1'b0;
      end else if (SKID != 0) begin
        if (out_xfer) begin
          if (skid_valid_q) begin
            main_d       = skid_q;
            skid_valid_d = in_xfer;
            if (in_xfer) skid_d = in_entry;
          end else if (in_xfer) begin
            main_d = in_entry;
          end else begin
            main_valid_d = 1'b0;
          end
        end else if (!main_valid_q) begin
          if (in_xfer) begin
            main_d       = in_entry;
            main_valid_d = 1'b1;
          end
        end else if (in_xfer) begin
          skid_d       = in_entry;
          skid_valid_d = 1'b1;
        end
      end else begin
        if (in_xfer) begin
          main_d       = in_entry;
          main_valid_d = 1'b1;
        end else if (out_xfer) begin
          main_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(negedge clock_i) begin
    if (reset_i) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      stall_q      <= '0;
      bubble_q     <= '0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      stall_q      <= stall_d;
      bubble_q     <= bubble_d;
    end
  end

  // Bubbles never expose stale control or halt to the next stage.
  assign valid_o         = main_valid_q;
  assign pc_o            = main_q.pc;
  assign data_o          = main_q.data;
  assign ctrl_o          = main_valid_q ? main_q.ctrl : '0;
  assign halt_detected_o = main_valid_q & main_q.halt;
  assign stall_count_o   = stall_q;
  assign bubble_count_o  = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a single-entry, 2-bit-counter
// instance share stimulus and are checked against a FIFO-level reference model.
module tb_pipe_stage_reg;

  localparam int NB_PC   = 32;
  localparam int NB_DATA = 16;
  localparam int NB_CTRL = 8;

  typedef struct packed {
    logic [NB_PC-1:0]   pc;
    logic [NB_DATA-1:0] data;
    logic [NB_CTRL-1:0] ctrl;
    logic               halt;
  } entry_t;

  logic clk;
  logic resetIn, enableIn, flushIn, validIn, readyIn, haltIn;
  logic [NB_PC-1:0]   pcIn;
  logic [NB_DATA-1:0] dataIn;
  logic [NB_CTRL-1:0] ctrlIn;

  logic               ready0, valid0, halt0, ready1, valid1, halt1;
  logic [NB_PC-1:0]   pc0, pc1;
  logic [NB_DATA-1:0] data0, data1;
  logic [NB_CTRL-1:0] ctrl0, ctrl1;
  logic [1:0]         stall0, bubble0;
  logic [15:0]        stall1, bubble1;

  int total = 0;
  int bad   = 0;

  // Reference model: index 0 = single-entry instance, index 1 = skid instance.
  entry_t          mBuf[2][2];
  int              mN[2];
  logic [NB_PC-1:0]   mPc[2];
  logic [NB_DATA-1:0] mData[2];
  int              mStall[2];
  int              mBubble[2];
  int              mMax[2];

  pipe_stage_reg #(.NB_PC(NB_PC), .NB_DATA(NB_DATA), .NB_CTRL(NB_CTRL),
                   .SKID(0), .NB_CNT(2)) dut0 (
    .clock_i(clk), .reset_i(resetIn), .enable_pipe_i(enableIn), .flush_i(flushIn),
    .valid_i(validIn), .ready_o(ready0), .pc_i(pcIn), .data_i(dataIn),
    .ctrl_i(ctrlIn), .halt_detected_i(haltIn), .valid_o(valid0), .ready_i(readyIn),
    .pc_o(pc0), .data_o(data0), .ctrl_o(ctrl0), .halt_detected_o(halt0),
    .stall_count_o(stall0), .bubble_count_o(bubble0));

  pipe_stage_reg #(.NB_PC(NB_PC), .NB_DATA(NB_DATA), .NB_CTRL(NB_CTRL),
                   .SKID(1), .NB_CNT(16)) dut1 (
    .clock_i(clk), .reset_i(resetIn), .enable_pipe_i(enableIn), .flush_i(flushIn),
    .valid_i(validIn), .ready_o(ready1), .pc_i(pcIn), .data_i(dataIn),
    .ctrl_i(ctrlIn), .halt_detected_i(haltIn), .valid_o(valid1), .ready_i(readyIn),
    .pc_o(pc1), .data_o(data1), .ctrl_o(ctrl1), .halt_detected_o(halt1),
    .stall_count_o(stall1), .bubble_count_o(bubble1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit modelReady(input int m);
    return (mN[m] < ((m == 1) ? 2 : 1)) || (m == 0 && readyIn);
  endfunction

  task automatic modelEdge(input int m);
    bit     inX, outX;
    entry_t e;
    e = '{pc: pcIn, data: dataIn, ctrl: ctrlIn, halt: haltIn};
    if (resetIn) begin
      mN[m] = 0; mPc[m] = '0; mData[m] = '0; mStall[m] = 0; mBubble[m] = 0;
    end else if (enableIn) begin
      if (mN[m] > 0 && !readyIn && mStall[m] < mMax[m]) mStall[m]++;
      if (mN[m] == 0 && mBubble[m] < mMax[m]) mBubble[m]++;
      if (flushIn) begin
        mN[m] = 0;
      end else begin
        inX  = validIn && modelReady(m);
        outX = (mN[m] > 0) && readyIn;
        if (outX) begin
          mBuf[m][0] = mBuf[m][1];
          mN[m]--;
        end
        if (inX) begin
          mBuf[m][mN[m]] = e;
          mN[m]++;
        end
        if (mN[m] > 0) begin
          mPc[m]   = mBuf[m][0].pc;
          mData[m] = mBuf[m][0].data;
        end
      end
    end
  endtask

  task automatic checkState(input int m);
    bit vExp;
    vExp = mN[m] > 0;
    checkOutput($sformatf("valid%0d", m), m ? valid1 : valid0, vExp);
    checkOutput($sformatf("pc%0d", m), m ? pc1 : pc0, mPc[m]);
    checkOutput($sformatf("data%0d", m), m ? data1 : data0, mData[m]);
    checkOutput($sformatf("ctrl%0d", m), m ? ctrl1 : ctrl0, vExp ? mBuf[m][0].ctrl : 8'h0);
    checkOutput($sformatf("halt%0d", m), m ? halt1 : halt0, vExp && mBuf[m][0].halt);
    checkOutput($sformatf("stall%0d", m), m ? stall1 : 64'(stall0), mStall[m]);
    checkOutput($sformatf("bubble%0d", m), m ? bubble1 : 64'(bubble0), mBubble[m]);
  endtask

  // One stage clock: drive inputs, check ready before the edge, then state after it.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic rdy,
                               input logic fl = 1'b0, input logic en = 1'b1,
                               input logic rs = 1'b0, input logic hlt = 1'b0);
    validIn  = v;
    pcIn     = pc;
    readyIn  = rdy;
    flushIn  = fl;
    enableIn = en;
    resetIn  = rs;
    haltIn   = hlt;
    dataIn   = NB_DATA'($urandom);
    ctrlIn   = NB_CTRL'($urandom);
    #1;
    checkOutput("ready0", ready0, modelReady(0));
    checkOutput("ready1", ready1, modelReady(1));
    modelEdge(0);
    modelEdge(1);
    @(negedge clk);
    #1;
    checkState(0);
    checkState(1);
  endtask

  initial begin
    mMax[0] = 3;
    mMax[1] = 65535;
    for (int m = 0; m < 2; m++) begin
      mN[m] = 0; mPc[m] = '0; mData[m] = '0; mStall[m] = 0; mBubble[m] = 0;
    end
    resetIn = 1'b1; enableIn = 1'b1; flushIn = 1'b0; validIn = 1'b0;
    readyIn = 1'b1; haltIn = 1'b0; pcIn = '0; dataIn = '0; ctrlIn = '0;

    // Reset with input offered: input must be dropped.
    applyStimulus(1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'hBEEF, 1'b0, 1'b1, 1'b0, 1'b1);

    // Streaming.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(4 * i), 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);

    // Backpressure: A, B, C offered while downstream stalls, then drain.
    applyStimulus(1'b1, 32'hA0, 1'b0);
    applyStimulus(1'b1, 32'hB0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hC0, 1'b0);
    checkOutput("skidFullReady", ready1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1);

    // Flush with both entries full and D offered.
    applyStimulus(1'b1, 32'h100, 1'b0);
    applyStimulus(1'b1, 32'h104, 1'b0);
    applyStimulus(1'b1, 32'hD0, 1'b0, 1'b1);
    checkOutput("flushValid", valid1, 1'b0);
    checkOutput("flushCtrl", ctrl1, 8'h0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 32'h0, 1'b1);

    // Enable freeze with an entry held.
    applyStimulus(1'b1, 32'h200, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h300, i[0], 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h304 + 32'(4 * i), 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);

    // Halt flag on pc 0x20, held for a couple of cycles then drained.
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);

    // Single-entry stall long enough to saturate the 2-bit counter.
    applyStimulus(1'b1, 32'h400, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'h404, 1'b0);
    checkOutput("satStall0", 64'(stall0), 64'd3);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Randomized traffic, occasional flush, freeze and reset.
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
